measurement_writer: RTL and testbench

//   Capture stage fed by the ADC AXI-Stream. On a software start it decimates the stream by
//   2^rate, writes 2^nr samples into a BRAM write port, then flags done in a status word.

---
 rtl/measurement_writer.sv | 123 ++++++++++++
 tb/tb_measurement_writer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/measurement_writer.sv
// Decimating capture stage: after a software start, stores every 2^rate-th valid
// stream beat into a BRAM write port until 2^nr samples are written, then reports done.
module measurement_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RATE_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           conf,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] bram_porta_addr,
  output logic [DATA_WIDTH-1:0] bram_porta_wrdata,
  output logic                  bram_porta_we,
  output logic [31:0]           sts
);

  localparam int RLW = $clog2(RATE_WIDTH + 1);
  localparam int NLW = $clog2(ADDR_WIDTH + 1);
  localparam logic [31:0] RATE_MAX = RATE_WIDTH;
  localparam logic [31:0] NR_MAX   = ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state, state_d;
  logic                  start_q;
  logic [RATE_WIDTH-1:0] rate_cnt;
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic [RLW-1:0]        rate_l;
  logic [NLW-1:0]        nr_l;

  logic                  start_ev;
  logic                  clear;
  logic                  rate_hit;
  logic                  capture;
  logic                  last;
  logic [RATE_WIDTH-1:0] rate_mask;
  logic [ADDR_WIDTH:0]   n_target;
  logic [ADDR_WIDTH:0]   wr_cnt_inc;

  assign s_axis_tready = 1'b1;

  assign start_ev   = conf[0] & ~start_q;
  assign clear      = conf[1];
  // Shifting all ones out when rate_l == RATE_WIDTH yields the full-width mask.
  assign rate_mask  = ~({RATE_WIDTH{1'b1}} << rate_l);
  assign rate_hit   = (rate_cnt == rate_mask);
  assign n_target   = {{ADDR_WIDTH{1'b0}}, 1'b1} << nr_l;
  assign wr_cnt_inc = wr_cnt + 1'b1;
  assign capture    = (state == S_RUN) && s_axis_tvalid && rate_hit;
  assign last       = capture && (wr_cnt_inc == n_target);

  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_ev) state_d = S_RUN;
        S_RUN:   if (last)     state_d = S_DONE;
        S_DONE:  if (start_ev) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      start_q           <= 1'b0;
      rate_cnt          <= '0;
      wr_cnt            <= '0;
      rate_l            <= '0;
      nr_l              <= '0;
      bram_porta_we     <= 1'b0;
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
    end else begin
      start_q       <= conf[0];
      bram_porta_we <= 1'b0;
      if (clear) begin
        rate_cnt <= '0;
        wr_cnt   <= '0;
      end else if ((state != S_RUN) && start_ev) begin
        rate_l   <= (32'(conf[28:24]) > RATE_MAX) ? RLW'(RATE_WIDTH) : RLW'(conf[28:24]);
        nr_l     <= (32'(conf[23:16]) > NR_MAX) ? NLW'(ADDR_WIDTH) : NLW'(conf[23:16]);
        rate_cnt <= '0;
        wr_cnt   <= '0;
      end else if ((state == S_RUN) && s_axis_tvalid) begin
        if (rate_hit) begin
          rate_cnt          <= '0;
          bram_porta_we     <= 1'b1;
          bram_porta_addr   <= wr_cnt[ADDR_WIDTH-1:0];
          bram_porta_wrdata <= s_axis_tdata;
          wr_cnt            <= wr_cnt_inc;
        end else begin
          rate_cnt <= rate_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sts                 = '0;
    sts[31]             = (state == S_DONE);
    sts[30]             = (state == S_RUN);
    sts[ADDR_WIDTH:0]   = wr_cnt;
  end

endmodule

// File: tb/tb_measurement_writer.sv
// Randomized bench for measurement_writer: stimulus tasks push expected BRAM writes,
// a negedge monitor pops and compares every write strobe; status checked after each run.
module tb_measurement_writer;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk;
  logic          aresetn;
  logic [31:0]   conf;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_wrdata;
  logic          bram_porta_we;
  logic [31:0]   sts;

  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  measurement_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RATE_WIDTH(16)) dut (
    .aclk              (clk),
    .aresetn           (aresetn),
    .conf              (conf),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_wrdata (bram_porta_wrdata),
    .bram_porta_we     (bram_porta_we),
    .sts               (sts)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (aresetn && bram_porta_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bram_porta_addr), 32'(e[AW+DW-1:DW]));
        check("wr_data", bram_porta_wrdata, e[DW-1:0]);
      end
    end
  end

  // abort_mode: 0 run to completion, 1 clear after abort_after writes, 2 reset after abort_after writes
  task automatic do_run(input int rate_f, input int nr_f, input int vmode,
                        input int abort_mode, input int abort_after, input bit hold_start);
    int r_pow, n, k, cap, budget;
    logic [31:0] ramp, d;
    logic v;
    logic [7:0] nr8;
    logic [4:0] rate5;
    r_pow = 1 << ((rate_f > 16) ? 16 : rate_f);
    n     = 1 << ((nr_f > AW) ? AW : nr_f);
    rate5 = rate_f[4:0];
    nr8   = nr_f[7:0];
    @(posedge clk); #1;
    conf = 32'h0;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    conf = {3'b000, rate5, nr8, 14'h0, 1'b0, 1'b1};
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_BEEF;   // seen while still idle, never stored
    k = 0; cap = 0; ramp = 0; budget = 0;
    while (cap < n && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
      if (abort_mode != 0 && cap == abort_after) break;
      conf[0] = hold_start ? 1'b1 : ($urandom_range(0, 7) == 0);
      case (vmode)
        0:       v = 1'b1;
        1:       v = budget[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_axis_tvalid = v;
      if (v) begin
        ramp = ramp + 1;
        d = (vmode == 2) ? $urandom : ramp;
        s_axis_tdata = d;
        k++;
        if (k % r_pow == 0) begin
          exp_q.push_back({cap[AW-1:0], d});
          cap++;
        end
      end else begin
        s_axis_tdata = $urandom;
      end
    end
    if (budget >= 20000) check("run_budget", 32'(cap), 32'(n));
    if (abort_mode == 1) begin
      conf = 32'h2;
      s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      check("clear_we", 32'(bram_porta_we), 32'd0);
      check("clear_sts", sts, 32'h0);
      conf = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("clear_hold_sts", sts, 32'h0);
      check("clear_queue_empty", 32'(exp_q.size()), 32'd0);
    end else if (abort_mode == 2) begin
      #1 aresetn = 1'b0;
      #1;
      check("rst_we_async", 32'(bram_porta_we), 32'd0);
      check("rst_sts", sts, 32'h0);
      exp_q.delete();
      conf = 32'h0;
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
    end else begin
      conf[0] = hold_start;
      s_axis_tvalid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("done_sts", sts, 32'h8000_0000 | 32'(n));
      check("done_queue_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    conf = 32'h0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(bram_porta_we), 32'd0);
    check("rst_addr", 32'(bram_porta_addr), 32'd0);
    check("rst_wrdata", bram_porta_wrdata, 32'd0);
    check("rst_sts0", sts, 32'h0);
    check("tready", 32'(s_axis_tready), 32'd1);
    @(negedge clk);
    aresetn = 1'b1;

    do_run(0, 2, 0, 0, 0, 1'b0);           // 4 writes, ramp 1..4
    check("t1_sts", sts, 32'h8000_0004);
    do_run(2, 3, 0, 0, 0, 1'b0);           // 8 writes, data 4,8,..,32
    do_run(1, 1, 1, 0, 0, 1'b0);           // toggling valid
    do_run(0, 8'hFF, 0, 0, 0, 1'b0);       // clamp to 1024, no wrap
    check("t4_sts_cnt", 32'(sts[10:0]), 32'd1024);
    do_run(0, 3, 0, 1, 3, 1'b0);           // clear after 3 writes
    do_run(0, 3, 2, 0, 0, 1'b0);           // fresh full run from addr 0
    do_run(1, 2, 0, 0, 0, 1'b1);           // start held high
    repeat (100) @(posedge clk);
    #1;
    check("held_start_sts", sts, 32'h8000_0004);
    check("held_start_queue", 32'(exp_q.size()), 32'd0);
    do_run(1, 4, 2, 2, 5, 1'b0);           // async reset mid-run
    for (int i = 0; i < 6; i++) begin
      do_run($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2), 0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
